// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between instruction fetch and load/store:
// round-robin arbitration, byte-lane steering and a stall watchdog.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_valid_o,
    output logic [31:0] if_rdata_o,
    output logic        if_err_o,
    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic        ls_bms_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_gnt_o,
    output logic        ls_valid_o,
    output logic [31:0] ls_rdata_o,
    output logic        ls_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;
    typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_e;

    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    function automatic logic [31:0] lane_load(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        return {{24{b[7]}}, b};
    endfunction

    state_e      state_q, state_d;
    owner_e      last_owner_q, last_owner_d;
    owner_e      owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        bms_q, bms_d;
    logic [1:0]  lane_q, lane_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        if_gnt_q, if_gnt_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        if_err_q, if_err_d;
    logic        ls_gnt_q, ls_gnt_d;
    logic        ls_valid_q, ls_valid_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        ls_err_q, ls_err_d;

    logic        pick_if_s;
    logic        pick_ls_s;
    logic [31:0] ls_result_s;

    // On a tie the port that did not own the previous transaction wins.
    assign pick_if_s = if_req_i && (!ls_req_i || (last_owner_q == OWN_LS));
    assign pick_ls_s = ls_req_i && (!if_req_i || (last_owner_q == OWN_IF));

    // Load/store completion data: stores return zero, byte loads are lane-extracted.
    always_comb begin
        ls_result_s = mem_rdata_i;
        if (mem_we_q) begin
            ls_result_s = 32'h0000_0000;
        end else if (bms_q) begin
            ls_result_s = lane_load(mem_rdata_i, lane_q);
        end else begin
            ls_result_s = mem_rdata_i;
        end
    end

    // Next-state and output logic of the IDLE/BUSY controller.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        bms_d        = bms_q;
        lane_d       = lane_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_gnt_d     = 1'b0;
        if_valid_d   = 1'b0;
        if_err_d     = 1'b0;
        if_rdata_d   = if_rdata_q;
        ls_gnt_d     = 1'b0;
        ls_valid_d   = 1'b0;
        ls_err_d     = 1'b0;
        ls_rdata_d   = ls_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_if_s) begin
                    state_d      = ST_BUSY;
                    mem_req_d    = 1'b1;
                    if_gnt_d     = 1'b1;
                    last_owner_d = OWN_IF;
                    owner_d      = OWN_IF;
                    cnt_d        = '0;
                    bms_d        = 1'b0;
                    lane_d       = if_addr_i[1:0];
                    mem_we_d     = 1'b0;
                    mem_be_d     = 4'hF;
                    mem_addr_d   = {if_addr_i[31:2], 2'b00};
                    mem_wdata_d  = 32'h0000_0000;
                end else if (pick_ls_s) begin
                    state_d      = ST_BUSY;
                    mem_req_d    = 1'b1;
                    ls_gnt_d     = 1'b1;
                    last_owner_d = OWN_LS;
                    owner_d      = OWN_LS;
                    cnt_d        = '0;
                    bms_d        = ls_bms_i;
                    lane_d       = ls_addr_i[1:0];
                    mem_we_d     = ls_we_i;
                    mem_addr_d   = {ls_addr_i[31:2], 2'b00};
                    if (ls_bms_i) begin
                        mem_be_d    = lane_be(ls_addr_i[1:0]);
                        mem_wdata_d = {4{ls_wdata_i[7:0]}};
                    end else begin
                        mem_be_d    = 4'hF;
                        mem_wdata_d = ls_wdata_i;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BUSY: begin
                // A ready on the watchdog's final cycle still completes normally.
                if (mem_ready_i) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata_i;
                    end else begin
                        ls_valid_d = 1'b1;
                        ls_rdata_d = ls_result_s;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_IF) begin
                        if_valid_d = 1'b1;
                        if_err_d   = 1'b1;
                        if_rdata_d = 32'h0000_0000;
                    end else begin
                        ls_valid_d = 1'b1;
                        ls_err_d   = 1'b1;
                        ls_rdata_d = 32'h0000_0000;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWN_LS;
            owner_q      <= OWN_IF;
            cnt_q        <= '0;
            bms_q        <= 1'b0;
            lane_q       <= 2'b00;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'h0;
            mem_addr_q   <= 32'h0000_0000;
            mem_wdata_q  <= 32'h0000_0000;
            if_gnt_q     <= 1'b0;
            if_valid_q   <= 1'b0;
            if_rdata_q   <= 32'h0000_0000;
            if_err_q     <= 1'b0;
            ls_gnt_q     <= 1'b0;
            ls_valid_q   <= 1'b0;
            ls_rdata_q   <= 32'h0000_0000;
            ls_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            bms_q        <= bms_d;
            lane_q       <= lane_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_gnt_q     <= if_gnt_d;
            if_valid_q   <= if_valid_d;
            if_rdata_q   <= if_rdata_d;
            if_err_q     <= if_err_d;
            ls_gnt_q     <= ls_gnt_d;
            ls_valid_q   <= ls_valid_d;
            ls_rdata_q   <= ls_rdata_d;
            ls_err_q     <= ls_err_d;
        end
    end

    assign if_gnt_o    = if_gnt_q;
    assign if_valid_o  = if_valid_q;
    assign if_rdata_o  = if_rdata_q;
    assign if_err_o    = if_err_q;
    assign ls_gnt_o    = ls_gnt_q;
    assign ls_valid_o  = ls_valid_q;
    assign ls_rdata_o  = ls_rdata_q;
    assign ls_err_o    = ls_err_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model of
// arbitration, lane steering, completion data and watchdog timing.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_gnt, if_valid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_bms, ls_gnt, ls_valid, ls_err;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_gnt_o    (if_gnt),
        .if_valid_o  (if_valid),
        .if_rdata_o  (if_rdata),
        .if_err_o    (if_err),
        .ls_req_i    (ls_req),
        .ls_we_i     (ls_we),
        .ls_bms_i    (ls_bms),
        .ls_addr_i   (ls_addr),
        .ls_wdata_i  (ls_wdata),
        .ls_gnt_o    (ls_gnt),
        .ls_valid_o  (ls_valid),
        .ls_rdata_o  (ls_rdata),
        .ls_err_o    (ls_err),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_be_o    (mem_be),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_ready_i (mem_ready),
        .mem_rdata_i (mem_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Pending requests and model state.
    logic        pend_if, pend_ls;
    logic [31:0] p_if_addr, p_ls_addr, p_ls_wdata;
    logic        p_ls_we, p_ls_bms;
    logic        last_ls;
    logic        hold_mode;
    logic [31:0] exp_if_rdata, exp_ls_rdata;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, 128'({if_gnt, if_valid, if_err, ls_gnt, ls_valid, ls_err,
                                      mem_req, mem_we, mem_be}), 128'(0));
        check_eq({tag, "_rdata"}, 128'({if_rdata, ls_rdata}), 128'(0));
        check_eq({tag, "_mem"}, 128'({mem_addr, mem_wdata}), 128'(0));
    endtask

    task automatic set_if(input logic [31:0] a);
        pend_if   = 1'b1;
        p_if_addr = a;
    endtask

    task automatic set_ls(input logic we, input logic bms, input logic [31:0] a, input logic [31:0] w);
        pend_ls    = 1'b1;
        p_ls_we    = we;
        p_ls_bms   = bms;
        p_ls_addr  = a;
        p_ls_wdata = w;
    endtask

    task automatic drive_reqs();
        if_req   = pend_if;
        if_addr  = p_if_addr;
        ls_req   = pend_ls;
        ls_we    = p_ls_we;
        ls_bms   = p_ls_bms;
        ls_addr  = p_ls_addr;
        ls_wdata = p_ls_wdata;
    endtask

    task automatic rand_reqs();
        if (!pend_if && ($urandom_range(0, 1) == 1)) set_if($urandom);
        if (!pend_ls && ($urandom_range(0, 1) == 1))
            set_ls(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
        if (!pend_if && !pend_ls) set_if($urandom);
    endtask

    task automatic idle_cycle();
        if_req = 1'b0;
        ls_req = 1'b0;
        @(posedge clk); #1;
        check_eq("idle", 128'({if_gnt, ls_gnt, mem_req}), 128'(0));
        @(negedge clk);
    endtask

    // One transaction from an IDLE negedge through to the next IDLE negedge.
    // lat = busy cycles before mem_ready; lat >= TIMEOUT means memory never answers.
    task automatic run_round(input int lat, input logic [31:0] rd);
        logic        win_ls;
        logic        e_we, e_err;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic [1:0]  lane;
        logic [7:0]  b;
        logic        done;
        drive_reqs();
        win_ls = (pend_if && pend_ls) ? !last_ls : pend_ls;
        if (win_ls) begin
            lane    = p_ls_addr[1:0];
            e_we    = p_ls_we;
            e_addr  = p_ls_addr & 32'hFFFF_FFFC;
            e_be    = p_ls_bms ? 4'(32'd1 << lane) : 4'hF;
            e_wdata = p_ls_bms ? 32'(p_ls_wdata[7:0]) * 32'h0101_0101 : p_ls_wdata;
        end else begin
            lane    = 2'd0;
            e_we    = 1'b0;
            e_addr  = p_if_addr & 32'hFFFF_FFFC;
            e_be    = 4'hF;
            e_wdata = 32'h0;
        end
        e_err = (lat >= TIMEOUT);
        if (e_err) begin
            e_rdata = 32'h0;
        end else if (win_ls && p_ls_we) begin
            e_rdata = 32'h0;
        end else if (win_ls && p_ls_bms) begin
            b       = 8'(rd >> (8 * int'(lane)));
            e_rdata = b[7] ? (32'(b) - 32'd256) : 32'(b);
        end else begin
            e_rdata = rd;
        end

        @(posedge clk); #1;
        check_eq("grant", 128'({if_gnt, ls_gnt, mem_req, if_valid, ls_valid}),
                 128'({!win_ls, win_ls, 1'b1, 1'b0, 1'b0}));
        check_eq("mem_fields", 128'({mem_we, mem_be, mem_addr, win_ls ? mem_wdata : 32'h0}),
                 128'({e_we, e_be, e_addr, e_wdata}));
        last_ls = win_ls;
        if (!hold_mode) begin
            if (win_ls) pend_ls = 1'b0;
            else        pend_if = 1'b0;
        end
        @(negedge clk);
        drive_reqs();

        done = 1'b0;
        for (int i = 0; i < TIMEOUT && !done; i++) begin
            mem_ready = (i == lat);
            mem_rdata = (i == lat) ? rd : $urandom;
            @(posedge clk); #1;
            if ((i == lat) || (i == TIMEOUT - 1)) begin
                done = 1'b1;
                if (win_ls) exp_ls_rdata = e_rdata;
                else        exp_if_rdata = e_rdata;
                check_eq("complete", 128'({if_valid, ls_valid, if_err, ls_err, mem_req, if_gnt, ls_gnt}),
                         128'({!win_ls, win_ls, e_err && !win_ls, e_err && win_ls, 3'b000}));
                check_eq("rdata", 128'({if_rdata, ls_rdata}), 128'({exp_if_rdata, exp_ls_rdata}));
            end else begin
                check_eq("busy", 128'({mem_req, if_valid, ls_valid, if_gnt, ls_gnt}), 128'(5'b10000));
                check_eq("busy_fields", 128'({mem_we, mem_be, mem_addr, win_ls ? mem_wdata : 32'h0}),
                         128'({e_we, e_be, e_addr, e_wdata}));
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
    endtask

    function automatic int rand_lat();
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0)      return TIMEOUT;
        else if (r == 1) return TIMEOUT - 1;
        else             return int'($urandom_range(0, 3));
    endfunction

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_bms = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        pend_if = 1'b0; pend_ls = 1'b0;
        p_if_addr = 32'h0; p_ls_addr = 32'h0; p_ls_wdata = 32'h0; p_ls_we = 1'b0; p_ls_bms = 1'b0;
        last_ls = 1'b1; hold_mode = 1'b0;
        exp_if_rdata = 32'h0; exp_ls_rdata = 32'h0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Lone fetch with a misaligned address and three wait cycles.
        set_if(32'h0000_0103);
        run_round(3, 32'h00A0_0093);
        check_eq("if_fetch_data", 128'(if_rdata), 128'(32'h00A0_0093));

        // Byte loads on lanes 2 and 1, then a byte store on lane 3.
        set_ls(1'b0, 1'b1, 32'h0000_0202, $urandom);
        run_round(1, 32'h12F4_5678);
        check_eq("lb_lane2", 128'(ls_rdata), 128'(32'hFFFF_FFF4));
        set_ls(1'b0, 1'b1, 32'h0000_0201, $urandom);
        run_round(0, 32'h12F4_5678);
        check_eq("lb_lane1", 128'(ls_rdata), 128'(32'h0000_0056));
        set_ls(1'b1, 1'b1, 32'h0000_0203, 32'h0000_00AB);
        run_round(2, $urandom);
        check_eq("sb_rdata", 128'(ls_rdata), 128'(32'h0));

        // Both ports requesting continuously with single-cycle memory.
        hold_mode = 1'b1;
        set_if($urandom);
        set_ls(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
        repeat (6) run_round(0, $urandom);
        hold_mode = 1'b0;
        pend_if = 1'b0;
        pend_ls = 1'b0;

        // Memory never answers, then the next request completes normally.
        set_ls(1'b0, 1'b0, 32'h0000_0300, $urandom);
        run_round(TIMEOUT, $urandom);
        check_eq("timeout_err", 128'({ls_err, ls_rdata}), 128'({1'b1, 32'h0}));
        set_ls(1'b0, 1'b0, 32'h0000_0304, $urandom);
        run_round(1, 32'hCAFE_F00D);
        check_eq("after_timeout", 128'(ls_rdata), 128'(32'hCAFE_F00D));

        repeat (150) begin
            if (!pend_if && !pend_ls && ($urandom_range(0, 3) == 0)) idle_cycle();
            rand_reqs();
            run_round(rand_lat(), $urandom);
        end

        // Asynchronous reset in the middle of a transaction.
        pend_if = 1'b0;
        pend_ls = 1'b0;
        set_ls(1'b0, 1'b0, 32'h0000_0400, $urandom);
        drive_reqs();
        @(posedge clk); #1;
        check_eq("pre_reset_busy", 128'(mem_req), 128'(1'b1));
        @(negedge clk);
        pend_ls = 1'b0;
        ls_req  = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        last_ls = 1'b1;
        exp_if_rdata = 32'h0;
        exp_ls_rdata = 32'h0;
        set_if($urandom);
        set_ls(1'b0, 1'b0, $urandom, $urandom);
        run_round(0, $urandom);
        check_eq("post_reset_tie", 128'(last_ls), 128'(1'b0));

        repeat (20) begin
            rand_reqs();
            run_round(rand_lat(), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
